uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single buffered UART transmitter between up to four byte producers, such as the message sender and a status/heartbeat reporter. Arbitration happens per message, not per byte: a granted requester keeps the transmitter until it hands over a byte marked last, or until a length guard forces release. This keeps messages uninterleaved on the serial line. The block sits between the producers and the transmitter's ready/valid byte channel.

## Interface
- NREQ, 4: number of requesters, 2..4.
- MAX_LEN, 16: maximum bytes per grant before forced release, 1..255.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_data  in  NREQ*8  byte from requester i in bits [8i+7:8i].
- req_valid  in  NREQ  requester i offers a byte.
- req_last  in  NREQ  the offered byte is the final byte of its message.
- req_ready  out  NREQ  byte from requester i accepted this cycle when req_ready[i] & req_valid[i].
- out_data  out  8  byte to the transmitter.
- out_valid  out  1  byte offered to the transmitter.
- out_ready  in  1  transmitter accepts.
- grant_id  out  2  index of the current or last granted requester.
- busy  out  1  high in LOCKED.

## Operation
- Reset state:
  - state IDLE, ptr 0, grant_id 0, beat count 0.
  - out_valid 0, out_data 0, req_ready 0, busy 0.
- IDLE:
  - out_valid=0; all req_ready=0.
  - If any req_valid is high, select the first valid index at or after ptr, in the order ptr, ptr+1, … modulo NREQ.
  - Register the winner into grant_id, clear the beat count, and go to LOCKED.
- LOCKED, all combinational from grant_id:
  - out_data=req_data[grant_id], out_valid=req_valid[grant_id].
  - req_ready[grant_id]=out_ready; all other req_ready=0.
- A beat is a cycle with out_valid & out_ready. On each beat the beat count increments (8-bit).
- Release: on a beat where req_last[grant_id]=1, or where the beat count equals MAX_LEN-1:
  - state goes to IDLE;
  - ptr becomes grant_id+1, wrapping NREQ-1→0;
  - grant_id holds its value.
- The granted requester may deassert valid mid-message. The grant is held with no timeout; other requesters wait.
- Bytes from non-granted requesters are never consumed.
- req_last is ignored unless a beat occurs in the same cycle.
- out_ready while out_valid=0 has no effect.
- Requester indices ≥ NREQ never win.

## Timing
- Arbitration latency: request seen in IDLE → first byte can be offered the next cycle. The minimum gap between messages is 1 idle cycle.
- Data path in LOCKED is zero-latency combinational pass-through; no byte is buffered internally.
- Back-to-back beats are accepted every cycle while out_ready and valid are both high.
- All state updates on the rising clk edge. reset has priority over every other update.
- Reset mid-message returns to IDLE immediately. The partially sent message is abandoned, and ptr restarts at 0.

## Test plan
- Single requester: req 1 sends 0x41,0x42,0x43 with last on 0x43, out_ready=1.
  - out_data shows 0x41,0x42,0x43 on 3 consecutive cycles, starting 1 cycle after valid.
  - grant_id=1; busy falls after the 0x43 beat; ptr=2.
- Simultaneous requests: reqs 0 and 2 valid from the cycle after reset, each with a 2-byte message.
  - Req 0's message goes first, then 1 idle cycle, then req 2's message.
  - Byte order is never interleaved.
- Round-robin wrap: reqs 0 and 3 continuously request 1-byte messages.
  - Grant sequence is 0,3,0,3.
  - ptr wraps 3→0 after req 3 is served.
- Backpressure and gap:
  - Hold out_ready=0 for 5 cycles mid-message: req_ready[grant] stays 0 and there is no beat.
  - Requester drops valid for 3 cycles: the grant is held and busy stays 1; the message then completes.
- Length guard: MAX_LEN=4, req 1 streams 6 bytes with no last.
  - Release occurs after the 4th beat.
  - With req 2 also pending, req 2 is granted next.
- Reset mid-message: assert reset after 2 of 5 bytes.
  - Next cycle: busy=0, out_valid=0, req_ready=0, grant_id=0.
  - After reset is released, arbitration starts from index 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one buffered UART transmitter among up to four
// byte producers. Arbitration is round-robin and per message. A granted
// requester keeps the transmitter until it sends a byte flagged last, or
// until the length guard forces release. The LOCKED data path is a pure
// combinational pass-through, so no byte is ever held inside this block.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAX_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        grant_id,
  output logic              busy
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Beat count at which the current beat is the last one allowed in a grant.
  localparam logic [7:0] LEN_LIMIT = 8'(MAX_LEN - 1);
  localparam logic [1:0] LAST_IDX  = 2'(NREQ - 1);

  state_t     state_r, state_s;
  logic [1:0] ptr_r, ptr_s;
  logic [1:0] grant_r, grant_s;
  logic [7:0] beat_cnt_r, beat_cnt_s;

  logic       locked_s;
  logic       sel_valid_s;
  logic       sel_last_s;
  logic [7:0] sel_data_s;
  logic [1:0] win_idx_s;
  logic [2:0] win_dist_s;
  logic       beat_s;

  assign locked_s = (state_r == ST_LOCKED);

  // Select the granted requester's byte, valid and last flag.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      sel_valid_s = sel_valid_s | (req_valid[i] & (grant_r == 2'(i)));
      sel_last_s  = sel_last_s  | (req_last[i]  & (grant_r == 2'(i)));
      sel_data_s  = sel_data_s  | (req_data[8*i +: 8] & {8{grant_r == 2'(i)}});
    end
  end

  // Round-robin pick: the valid requester closest to ptr, counting upward
  // modulo NREQ.
  always_comb begin
    int dist_v;
    logic take_v;
    win_idx_s  = 2'd0;
    win_dist_s = 3'(NREQ);
    dist_v     = 0;
    take_v     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      dist_v     = i - int'(ptr_r);
      dist_v     = (dist_v < 0) ? dist_v + NREQ : dist_v;
      take_v     = req_valid[i] & (3'(dist_v) < win_dist_s);
      win_idx_s  = take_v ? 2'(i) : win_idx_s;
      win_dist_s = take_v ? 3'(dist_v) : win_dist_s;
    end
  end

  // Drive the transmitter channel and the ready lines back to the producers.
  always_comb begin
    out_valid = locked_s & sel_valid_s;
    out_data  = locked_s ? sel_data_s : 8'h00;
    busy      = locked_s;
    grant_id  = grant_r;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = locked_s & out_ready & (grant_r == 2'(i));
    end
  end

  assign beat_s = out_valid & out_ready;

  // Compute the next arbitration state, grant, pointer and beat count.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    grant_s    = grant_r;
    beat_cnt_s = beat_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          state_s    = ST_LOCKED;
          grant_s    = win_idx_s;
          beat_cnt_s = 8'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (beat_s) begin
          beat_cnt_s = beat_cnt_r + 8'd1;
          if (sel_last_s || (beat_cnt_r == LEN_LIMIT)) begin
            state_s = ST_IDLE;
            ptr_s   = (grant_r == LAST_IDX) ? 2'd0 : grant_r + 2'd1;
          end else begin
            state_s = ST_LOCKED;
          end
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        ptr_s      = 2'd0;
        grant_s    = 2'd0;
        beat_cnt_s = 8'd0;
      end
    endcase
  end

  // State registers; reset abandons any message in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ptr_r      <= 2'd0;
      grant_r    <= 2'd0;
      beat_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      grant_r    <= grant_s;
      beat_cnt_r <= beat_cnt_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios with literal expectations, then
// randomized producers and transmitter backpressure. A message-level
// reference model predicts busy, grant_id, out_valid, out_data and
// req_ready on every cycle.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int ML = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  grant_id;
  logic        busy;

  uart_tx_arbiter #(.NREQ(N), .MAX_LEN(ML)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Producer state: pending bytes per requester and their last flags.
  logic [7:0] q_data [N][$];
  logic       q_last [N][$];
  int         vprob [N];
  int         rprob;
  logic       rst_req;

  // Reference model: grant ownership at message level.
  logic m_locked;
  int   m_grant;
  int   m_ptr;
  int   m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input logic l);
    q_data[i].push_back(d);
    q_last[i].push_back(l);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      q_data[i].delete();
      q_last[i].delete();
    end
  endtask

  task automatic drive_inputs();
    logic [31:0] d;
    logic [3:0]  v;
    logic [3:0]  l;
    d = 32'h0;
    v = 4'h0;
    l = 4'h0;
    for (int i = 0; i < N; i++) begin
      if (q_data[i].size() > 0 && int'($urandom_range(99)) < vprob[i]) begin
        v[i]         = 1'b1;
        d[8*i +: 8]  = q_data[i][0];
        l[i]         = q_last[i][0];
      end else begin
        v[i]         = 1'b0;
        d[8*i +: 8]  = 8'($urandom);
        l[i]         = 1'($urandom);
      end
    end
    req_data  = d;
    req_valid = v;
    req_last  = l;
    out_ready = (int'($urandom_range(99)) < rprob);
    reset     = rst_req;
  endtask

  task automatic compare_and_model();
    logic       e_valid;
    logic [3:0] e_ready;
    logic [7:0] e_data;
    logic       cur_last;
    e_valid  = m_locked && req_valid[2'(m_grant)];
    e_ready  = (m_locked && out_ready) ? 4'(1 << m_grant) : 4'h0;
    e_data   = req_data[8*m_grant +: 8];
    cur_last = req_last[2'(m_grant)];
    chk("busy", 32'(busy), 32'(m_locked));
    chk("grant_id", 32'(grant_id), 32'(m_grant));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    if (e_valid) begin
      chk("out_data", 32'(out_data), 32'(e_data));
    end
    // Producers see their byte consumed wherever ready meets valid.
    for (int i = 0; i < N; i++) begin
      if (e_ready[i] && req_valid[i]) begin
        void'(q_data[i].pop_front());
        void'(q_last[i].pop_front());
      end
    end
    if (reset) begin
      m_locked = 1'b0;
      m_grant  = 0;
      m_ptr    = 0;
      m_cnt    = 0;
    end else if (!m_locked) begin
      if (req_valid != 4'h0) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (req_valid[2'((m_ptr + k) % N)]) m_grant = (m_ptr + k) % N;
        end
        m_locked = 1'b1;
        m_cnt    = 0;
      end
    end else if (e_valid && out_ready) begin
      if (cur_last || m_cnt == ML - 1) begin
        m_locked = 1'b0;
        m_ptr    = (m_grant + 1) % N;
      end
      m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_inputs();
    @(negedge clk);
    compare_and_model();
  endtask

  task automatic do_reset();
    clear_queues();
    rst_req = 1'b1;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    rst_req = 1'b0;
  endtask

  initial begin
    rst_req   = 1'b1;
    reset     = 1'b1;
    req_data  = 32'h0;
    req_valid = 4'h0;
    req_last  = 4'h0;
    out_ready = 1'b0;
    rprob     = 100;
    for (int i = 0; i < N; i++) vprob[i] = 100;
    m_locked = 1'b0;
    m_grant  = 0;
    m_ptr    = 0;
    m_cnt    = 0;

    // Single requester, three-byte message, then ptr must sit at 2.
    do_reset();
    push_byte(1, 8'h41, 1'b0);
    push_byte(1, 8'h42, 1'b0);
    push_byte(1, 8'h43, 1'b1);
    step(); chk("t1_idle_valid", 32'(out_valid), 32'h0);
    step(); chk("t1_byte0", 32'(out_data), 32'h41); chk("t1_grant", 32'(grant_id), 32'h1);
    step(); chk("t1_byte1", 32'(out_data), 32'h42);
    step(); chk("t1_byte2", 32'(out_data), 32'h43); chk("t1_busy_last", 32'(busy), 32'h1);
    step(); chk("t1_busy_after", 32'(busy), 32'h0); chk("t1_grant_hold", 32'(grant_id), 32'h1);
    push_byte(0, 8'h50, 1'b1);
    push_byte(3, 8'h53, 1'b1);
    step();
    step(); chk("t1_ptr2_grant", 32'(grant_id), 32'h3); chk("t1_ptr2_data", 32'(out_data), 32'h53);
    step();
    step(); chk("t1_next_grant", 32'(grant_id), 32'h0); chk("t1_next_data", 32'(out_data), 32'h50);
    step();

    // Simultaneous requests from 0 and 2: messages stay whole, one idle gap.
    do_reset();
    push_byte(0, 8'hA0, 1'b0); push_byte(0, 8'hA1, 1'b1);
    push_byte(2, 8'hB0, 1'b0); push_byte(2, 8'hB1, 1'b1);
    step();
    step(); chk("t2_a0", 32'(out_data), 32'hA0); chk("t2_g0", 32'(grant_id), 32'h0);
    step(); chk("t2_a1", 32'(out_data), 32'hA1);
    step(); chk("t2_gap", 32'(busy), 32'h0);
    step(); chk("t2_b0", 32'(out_data), 32'hB0); chk("t2_g2", 32'(grant_id), 32'h2);
    step(); chk("t2_b1", 32'(out_data), 32'hB1);
    step();

    // Round-robin wrap between 0 and 3.
    do_reset();
    push_byte(0, 8'h01, 1'b1); push_byte(0, 8'h02, 1'b1);
    push_byte(3, 8'h31, 1'b1); push_byte(3, 8'h32, 1'b1);
    step();
    step(); chk("t3_g_a", 32'(grant_id), 32'h0); chk("t3_d_a", 32'(out_data), 32'h01);
    step(); chk("t3_gap", 32'(busy), 32'h0);
    step(); chk("t3_g_b", 32'(grant_id), 32'h3); chk("t3_d_b", 32'(out_data), 32'h31);
    step();
    step(); chk("t3_g_c", 32'(grant_id), 32'h0); chk("t3_d_c", 32'(out_data), 32'h02);
    step();
    step(); chk("t3_g_d", 32'(grant_id), 32'h3); chk("t3_d_d", 32'(out_data), 32'h32);
    step();

    // Backpressure and a valid gap from the granted requester.
    do_reset();
    push_byte(2, 8'hC0, 1'b0); push_byte(2, 8'hC1, 1'b0); push_byte(2, 8'hC2, 1'b1);
    step();
    step(); chk("t4_c0", 32'(out_data), 32'hC0);
    push_byte(1, 8'hD0, 1'b1);
    rprob = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t4_bp_ready", 32'(req_ready), 32'h0);
      chk("t4_bp_data", 32'(out_data), 32'hC1);
    end
    rprob = 100;
    vprob[2] = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t4_gap_busy", 32'(busy), 32'h1);
      chk("t4_gap_valid", 32'(out_valid), 32'h0);
      chk("t4_gap_ready", 32'(req_ready), 32'h4);
    end
    vprob[2] = 100;
    step(); chk("t4_c1", 32'(out_data), 32'hC1);
    step(); chk("t4_c2", 32'(out_data), 32'hC2);
    step();
    step(); chk("t4_d0_grant", 32'(grant_id), 32'h1); chk("t4_d0", 32'(out_data), 32'hD0);
    step();

    // Length guard forces release after the fourth beat; req 2 goes next.
    do_reset();
    for (int b = 0; b < 6; b++) push_byte(1, 8'(8'hE0 + b), 1'b0);
    push_byte(2, 8'hF0, 1'b1);
    step();
    step(); chk("t5_e0", 32'(out_data), 32'hE0);
    step();
    step();
    step(); chk("t5_e3", 32'(out_data), 32'hE3); chk("t5_busy4", 32'(busy), 32'h1);
    step(); chk("t5_released", 32'(busy), 32'h0);
    step(); chk("t5_next_grant", 32'(grant_id), 32'h2); chk("t5_f0", 32'(out_data), 32'hF0);
    step();

    // Reset in the middle of a five-byte message.
    do_reset();
    for (int b = 0; b < 5; b++) push_byte(3, 8'(8'h70 + b), (b == 4) ? 1'b1 : 1'b0);
    step();
    step(); chk("t6_g0", 32'(out_data), 32'h70);
    step(); chk("t6_g1", 32'(out_data), 32'h71);
    rst_req = 1'b1;
    push_byte(0, 8'h60, 1'b1);
    step();
    rst_req = 1'b0;
    step();
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_valid", 32'(out_valid), 32'h0);
    chk("t6_ready", 32'(req_ready), 32'h0);
    chk("t6_grant", 32'(grant_id), 32'h0);
    step(); chk("t6_restart_grant", 32'(grant_id), 32'h0); chk("t6_restart_data", 32'(out_data), 32'h60);
    for (int c = 0; c < 6; c++) step();

    // Randomized traffic with occasional resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        for (int i = 0; i < N; i++) vprob[i] = int'($urandom_range(100, 40));
        rprob = int'($urandom_range(100, 50));
      end
      for (int i = 0; i < N; i++) begin
        if (q_data[i].size() < 3 && $urandom_range(3) == 0) begin
          int len;
          len = int'($urandom_range(6, 1));
          for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), (b == len - 1) ? 1'b1 : 1'b0);
        end
      end
      rst_req = ($urandom_range(999) == 0) ? 1'b1 : 1'b0;
      step();
    end
    rst_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
